// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state type and index helpers for conv_window_mac
package conv_pkg;

  localparam int MODE_BINARY = 0;
  localparam int MODE_SIGNED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_e;

  // Never returns less than 1 so single-entry ranges still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tap_idx(input int ch, input int j, input int kk);
    return ch * kk + j;
  endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// rtl/conv_kernel_bank.sv - CH*K*K weight register file with gated writes and per-channel read
module conv_kernel_bank
  import conv_pkg::*;
#(
  parameter int K  = 3,
  parameter int CH = 1,
  parameter int WW = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [clog2(CH*K*K)-1:0]   wr_addr,
  input  logic [WW-1:0]              wr_data,
  input  logic [clog2(CH)-1:0]       rd_ch,
  output logic [K*K*WW-1:0]          rd_w
);

  localparam int KK = K * K;
  localparam int N  = CH * KK;
  localparam int AW = clog2(N);
  localparam logic [AW:0] N_LIM = (AW + 1)'(N);

  logic [WW-1:0] bank [N];
  logic          wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < N_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
    end else if (wr_ok) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // A write landing on the tap being read is forwarded, so a beat accepted
  // in the same cycle as the write already sees the new weight.
  always_comb begin
    logic [AW-1:0] idx;
    rd_w = '0;
    idx  = '0;
    for (int j = 0; j < KK; j++) begin
      idx = AW'(tap_idx(int'(rd_ch), j, KK));
      rd_w[j*WW +: WW] = (wr_ok && (wr_addr == idx)) ? wr_data : bank[idx];
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - pipelined K*K*CH window multiply-accumulate with back-pressured output
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int K     = 3,
  parameter int CH    = 1,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 32,
  parameter int MODE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      kw_en,
  input  logic [clog2(CH*K*K)-1:0]  kw_addr,
  input  logic [WW-1:0]             kw_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [K*K*DW-1:0]         in_win,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_sum,
  output logic                      busy
);

  localparam int KK = K * K;
  localparam int CW = clog2(CH);
  localparam int PW = DW + WW;

  conv_state_e state, state_nx;

  logic              stall, accept, beat_first, beat_last;
  logic [CW-1:0]     ch_cnt;
  logic [KK*WW-1:0]  w_cur;
  logic [ACC_W-1:0]  prod_c [KK];
  logic [ACC_W-1:0]  s1_prod [KK];
  logic              s1_valid, s1_first, s1_last;
  logic [ACC_W-1:0]  sum_c, s2_sum;
  logic              s2_valid, s2_first, s2_last;
  logic [ACC_W-1:0]  acc, acc_nx;

  // A held result freezes the whole pipe, including the input.
  assign stall      = out_valid & ~out_ready;
  assign in_ready   = rst_n & ~stall;
  assign accept     = in_valid & in_ready;
  assign busy       = (state == ST_RUN);
  assign beat_first = (ch_cnt == '0);
  assign beat_last  = (ch_cnt == CW'(CH - 1));

  conv_kernel_bank #(
    .K  (K),
    .CH (CH),
    .WW (WW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (kw_en & (state == ST_IDLE)),
    .wr_addr (kw_addr),
    .wr_data (kw_data),
    .rd_ch   (ch_cnt),
    .rd_w    (w_cur)
  );

  for (genvar j = 0; j < KK; j++) begin : g_tap
    logic [DW-1:0] pix;
    logic [WW-1:0] wt;
    assign pix = in_win[j*DW +: DW];
    assign wt  = w_cur[j*WW +: WW];
    if (MODE == MODE_SIGNED) begin : g_signed
      logic signed [PW-1:0] p;
      assign p         = $signed(pix) * $signed(wt);
      assign prod_c[j] = ACC_W'({{ACC_W{p[PW-1]}}, p});
    end else begin : g_binary
      logic unused_taps;
      assign unused_taps = ^{pix, wt};
      assign prod_c[j]   = {{(ACC_W-1){1'b0}}, pix[0] & wt[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= beat_last ? '0 : ch_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int j = 0; j < KK; j++) s1_prod[j] <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_first <= beat_first;
      s1_last  <= beat_last;
      for (int j = 0; j < KK; j++) s1_prod[j] <= prod_c[j];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int j = 0; j < KK; j++) sum_c = sum_c + s1_prod[j];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
    end
  end

  assign acc_nx = s2_first ? s2_sum : acc + s2_sum;

  // Unstalled means any held result is being taken, so out_valid simply
  // follows whether a new last beat arrives this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (!stall) begin
      if (s2_valid) acc <= acc_nx;
      out_valid <= s2_valid & s2_last;
      if (s2_valid && s2_last) out_sum <= acc_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN: begin
        if (!accept && !s1_valid && !s2_valid && (ch_cnt == '0) &&
            (!out_valid || out_ready))
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - directed self-checking bench for conv_window_mac
module tb_conv_window_mac;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: K=3 CH=2 signed 32-bit; b: CH=1 binary; c: CH=1 signed 8-bit accumulator
  logic        a_kw_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [4:0]  a_kw_addr;
  logic [7:0]  a_kw_data;
  logic [71:0] a_in_win;
  logic [31:0] a_out_sum;

  logic        b_kw_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [3:0]  b_kw_addr;
  logic [7:0]  b_kw_data;
  logic [71:0] b_in_win;
  logic [31:0] b_out_sum;

  logic        c_kw_en, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [3:0]  c_kw_addr;
  logic [7:0]  c_kw_data;
  logic [71:0] c_in_win;
  logic [7:0]  c_out_sum;

  conv_window_mac #(.K(3), .CH(2), .DW(8), .WW(8), .ACC_W(32), .MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .kw_en(a_kw_en), .kw_addr(a_kw_addr), .kw_data(a_kw_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_win(a_in_win),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .busy(a_busy)
  );

  conv_window_mac #(.K(3), .CH(1), .DW(8), .WW(8), .ACC_W(32), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .kw_en(b_kw_en), .kw_addr(b_kw_addr), .kw_data(b_kw_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_win(b_in_win),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .busy(b_busy)
  );

  conv_window_mac #(.K(3), .CH(1), .DW(8), .WW(8), .ACC_W(8), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .kw_en(c_kw_en), .kw_addr(c_kw_addr), .kw_data(c_kw_data),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_win(c_in_win),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum), .busy(c_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_a [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  task automatic kw_a(input logic [4:0] addr, input logic [7:0] data);
    a_kw_en = 1'b1; a_kw_addr = addr; a_kw_data = data;
    @(negedge clk);
    a_kw_en = 1'b0;
  endtask

  task automatic kw_b(input logic [3:0] addr, input logic [7:0] data);
    b_kw_en = 1'b1; b_kw_addr = addr; b_kw_data = data;
    @(negedge clk);
    b_kw_en = 1'b0;
  endtask

  task automatic kw_c(input logic [3:0] addr, input logic [7:0] data);
    c_kw_en = 1'b1; c_kw_addr = addr; c_kw_data = data;
    @(negedge clk);
    c_kw_en = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_a(input logic [71:0] w);
    bit done;
    done = 1'b0;
    a_in_valid = 1'b1;
    a_in_win   = w;
    for (int n = 0; n < 50 && !done; n++) begin
      #4;
      done = a_in_ready;
      @(negedge clk);
    end
    if (!done) check("a_send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain_a();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #3;
      if (exp_a.size() == 0 && !a_busy) break;
    end
    check("a_drain_left", 32'(exp_a.size()), 32'd0);
    check("a_drain_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_c(input string tag, input logic [71:0] w, input logic [7:0] exp);
    bit seen;
    seen = 1'b0;
    c_in_valid = 1'b1;
    c_in_win   = w;
    @(negedge clk);
    c_in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #2;
      if (c_out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check(tag, {24'd0, c_out_sum}, {24'd0, exp});
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) check("a_unexpected_out", 32'(a_out_valid), 32'd0);
      else check("a_result", a_out_sum, exp_a.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [71:0] w1, w2;
    logic [8:0]  pat;
    bit          seen;

    rst_n = 1'b0;
    a_kw_en = 0; a_kw_addr = 0; a_kw_data = 0; a_in_valid = 0; a_in_win = 0; a_out_ready = 1;
    b_kw_en = 0; b_kw_addr = 0; b_kw_data = 0; b_in_valid = 0; b_in_win = 0; b_out_ready = 1;
    c_kw_en = 0; c_kw_addr = 0; c_kw_data = 0; c_in_valid = 0; c_in_win = 0; c_out_ready = 1;

    repeat (2) @(negedge clk);
    #2;
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_sum", a_out_sum, 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_c_sum", {24'd0, c_out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    @(negedge clk);

    // two-channel accumulate and latency
    for (int i = 0; i < 9; i++)  kw_a(5'(i), 8'd1);
    for (int i = 9; i < 18; i++) kw_a(5'(i), 8'd2);
    exp_a.push_back(32'd9);
    send_a(fill(8'd3));
    send_a(fill(8'hFF));
    a_in_valid = 1'b0;
    #2;
    check("a_lat_t1", 32'(a_out_valid), 32'd0);
    @(negedge clk); #2;
    check("a_lat_t2", 32'(a_out_valid), 32'd0);
    @(negedge clk); #2;
    check("a_lat_t3", 32'(a_out_valid), 32'd1);
    check("a_lat_sum", a_out_sum, 32'd9);
    drain_a();

    // output back-pressure for 5 cycles with results queued behind
    exp_a.push_back(32'd27);
    exp_a.push_back(32'd18);
    exp_a.push_back(32'hFFFF_FFEE);
    exp_a.push_back(32'd135);
    fork
      begin
        send_a(fill(8'd1)); send_a(fill(8'd1));
        send_a(fill(8'd2)); send_a(fill(8'd0));
        send_a(fill(8'd0)); send_a(fill(8'hFF));
        send_a(fill(8'd5)); send_a(fill(8'd5));
        a_in_valid = 1'b0;
      end
      begin
        logic [31:0] held;
        bit          got_v;
        got_v = 1'b0;
        a_out_ready = 1'b0;
        for (int n = 0; n < 40; n++) begin
          #2;
          if (a_out_valid) begin got_v = 1'b1; break; end
          @(negedge clk);
        end
        check("a_stall_seen", 32'(got_v), 32'd1);
        held = a_out_sum;
        check("a_stall_first", held, 32'd27);
        repeat (5) begin
          @(negedge clk); #2;
          check("a_stall_in_ready", 32'(a_in_ready), 32'd0);
          check("a_stall_valid", 32'(a_out_valid), 32'd1);
          check("a_stall_hold", a_out_sum, held);
        end
        @(negedge clk);
        a_out_ready = 1'b1;
      end
    join
    drain_a();

    // kernel write while busy is dropped
    exp_a.push_back(32'd9);
    send_a(fill(8'd1));
    check("a_busy_run", 32'(a_busy), 32'd1);
    a_kw_en = 1'b1; a_kw_addr = 5'd0; a_kw_data = 8'd7;
    send_a(fill(8'd0));
    a_kw_en = 1'b0;
    a_in_valid = 1'b0;
    drain_a();

    // idle write lands; out-of-range write ignored
    kw_a(5'd0, 8'd7);
    kw_a(5'd31, 8'd99);
    exp_a.push_back(32'd15);
    send_a(fill(8'd1));
    send_a(fill(8'd0));
    a_in_valid = 1'b0;
    drain_a();

    // write in the same cycle as the first beat is used by that beat
    exp_a.push_back(32'd17);
    a_kw_en = 1'b1; a_kw_addr = 5'd1; a_kw_data = 8'd3;
    send_a(fill(8'd1));
    a_kw_en = 1'b0;
    send_a(fill(8'd0));
    a_in_valid = 1'b0;
    drain_a();

    // binary mode, back-to-back stream
    for (int j = 0; j < 9; j++) kw_b(4'(j), (j % 2 == 0) ? 8'h03 : 8'h02);
    pat = 9'b111000111;
    for (int j = 0; j < 9; j++) w1[j*8 +: 8] = pat[j] ? 8'hA1 : 8'hFE;
    w2 = fill(8'h81);
    check("b_in_ready", 32'(b_in_ready), 32'd1);
    fork
      begin
        b_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
          b_in_win = (i % 2 == 0) ? w1 : w2;
          @(negedge clk);
        end
        b_in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
          #2;
          if (b_out_valid) begin seen = 1'b1; break; end
          @(negedge clk);
        end
        check("b_first_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 8; i++) begin
          check("b_stream_valid", 32'(b_out_valid), 32'd1);
          check("b_stream_sum", b_out_sum, (i % 2 == 0) ? 32'd4 : 32'd5);
          @(negedge clk); #2;
        end
        check("b_stream_end", 32'(b_out_valid), 32'd0);
      end
    join
    @(negedge clk);

    // 8-bit accumulator wrap
    for (int j = 0; j < 9; j++) kw_c(4'(j), 8'd127);
    run_c("c_wrap_pos", fill(8'd127), 8'h09);
    run_c("c_wrap_neg", fill(8'h80), 8'h80);

    // reset mid-accumulation
    send_a(fill(8'd5));
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("a_rst_in_ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      #2;
      check("a_rst_no_valid", 32'(a_out_valid), 32'd0);
      @(negedge clk);
    end
    check("a_rst_sum", a_out_sum, 32'd0);
    check("a_rst_busy", 32'(a_busy), 32'd0);
    exp_a.push_back(32'd0);
    send_a(fill(8'd3));
    send_a(fill(8'd4));
    a_in_valid = 1'b0;
    drain_a();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
